// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_pkg
// Brief    : shared state encoding and default width for the serial subtractor
// Revision : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    localparam int c_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : full_subtractor
// Brief    : one-bit full subtractor, d = a - b - bin with borrow-out
// Revision : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_sub4.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub4
// Brief    : bit-serial unsigned subtractor, LSB first, valid/ready handshake
// Revision : 1.0 - initial release
// ============================================================================
module serial_sub4
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero
);

    localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_d;
    logic              r_br;
    logic              r_bout;
    logic              r_zero;
    logic [c_CW-1:0]   r_cnt;

    logic              w_d;
    logic              w_bout;
    logic [WIDTH-1:0]  w_d_next;

    full_subtractor u_fs (
        .a    (r_a[r_cnt]),
        .b    (r_b[r_cnt]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    // Result word with the bit being processed this cycle merged in, so the
    // zero flag can be registered on the same edge as the final bit.
    always_comb begin
        w_d_next        = r_d;
        w_d_next[r_cnt] = w_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_d         <= '0;
            r_br        <= 1'b0;
            r_bout      <= 1'b0;
            r_zero      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_br       <= bin;
                        r_cnt      <= '0;
                        r_d        <= '0;
                        r_bout     <= 1'b0;
                        r_zero     <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_d   <= w_d_next;
                    r_br  <= w_bout;
                    r_cnt <= r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        r_bout      <= w_bout;
                        r_zero      <= (w_d_next == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign d         = r_d;
    assign bout      = r_bout;
    assign zero      = r_zero;

endmodule
`default_nettype wire
